// File: rtl/memory_map.sv
// memory_map: shared types and constants for the settings register bank.
//   fpga_settings_t   - packed settings image, byte 0 is the least significant byte
//   settings_union_t  - same image viewed as an array of bytes
//   DefaultSettings   - image loaded by reset
//   StructBytes       - image size in bytes
//   AddrReadOnly      - highest read-only byte address
//   permission_t      - per-byte access class
//   bank_state_t      - bank controller states
package memory_map;

  // Fields are listed MSB first, so device_id occupies bytes 0..1.
  typedef struct packed {
    logic [31:0] scratch;    // bytes 12..15
    logic [31:0] gain;       // bytes 8..11
    logic [31:0] ctrl;       // bytes 4..7
    logic [15:0] version;    // bytes 2..3 (read-only)
    logic [15:0] device_id;  // bytes 0..1 (read-only)
  } fpga_settings_t;

  localparam int StructBytes  = $bits(fpga_settings_t) / 8;
  localparam int AddrReadOnly = 3;

  typedef union packed {
    fpga_settings_t                   fields;
    logic [StructBytes-1:0][7:0]      bytes;
  } settings_union_t;

  localparam fpga_settings_t DefaultSettings = '{
    scratch:   32'h0000_0000,
    gain:      32'h0000_0100,
    ctrl:      32'h0000_0001,
    version:   16'h0102,
    device_id: 16'hA55A
  };

  typedef enum logic [1:0] {
    PermLocked,
    PermReadOnly,
    PermReadWrite
  } permission_t;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    COMMIT
  } bank_state_t;

  // Reset value of one image byte; bytes past the struct reset to zero.
  function automatic logic [7:0] default_byte(input int idx);
    logic [$bits(fpga_settings_t)-1:0] v;
    v = DefaultSettings;
    v = v >> (8 * idx);
    return v[7:0];
  endfunction

endpackage

// File: rtl/settings_perm_decode.sv
// settings_perm_decode: classifies one byte address of the settings image.
//   i_addr - byte address
//   o_perm - PermLocked past the image, PermReadOnly up to RO_LAST,
//            PermReadWrite otherwise
module settings_perm_decode
  import memory_map::*;
#(
  parameter int ADDR_W    = 8,
  parameter int NUM_BYTES = StructBytes,
  parameter int RO_LAST   = AddrReadOnly
) (
  input  logic [ADDR_W-1:0] i_addr,
  output permission_t       o_perm
);

  logic [31:0] w_addr;
  assign w_addr = 32'(i_addr);

  always_comb begin
    o_perm = PermReadWrite;
    if (w_addr >= 32'(NUM_BYTES)) begin
      o_perm = PermLocked;
    end else if (w_addr <= 32'(RO_LAST)) begin
      o_perm = PermReadOnly;
    end
  end

endmodule

// File: rtl/settings_shadow_bank.sv
// settings_shadow_bank: byte-addressed settings image with an optional shadow
// copy that is transferred to the active image on a commit request.
//
// Build option: SETTINGS_SHADOW_EN
//   defined   - writes/reads use the shadow copy, current_settings changes
//               only when a commit executes, shadow_dirty tracks pending edits
//   undefined - single copy written directly, shadow_dirty tied low; a commit
//               still runs through COMMIT and pulses commit_done
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (one outstanding access)
//   req_write, req_addr           direction and aligned byte address
//   req_wdata, req_wstrb          little-endian write data and byte enables
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            read data and fault flag
//   commit, commit_done           commit request pulse / completion pulse
//   shadow_dirty                  shadow holds unapplied writes
//   current_settings              active image
module settings_shadow_bank
  import memory_map::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_BYTES = StructBytes,
  parameter int RO_LAST   = AddrReadOnly
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                commit,
  output logic                commit_done,
  output logic                shadow_dirty,
  output fpga_settings_t      current_settings
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);

  bank_state_t       r_state;
  bank_state_t       w_state_next;
  logic              r_commit_pend;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_lane_rdata;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              w_rsp_err;
  logic [NB-1:0]     w_lane_we;
  logic [NB-1:0]     w_lane_bad;
  logic [ADDR_W-1:0] w_lane_addr [NB];
  logic [IDX_W-1:0]  w_lane_idx  [NB];
  permission_t       w_lane_perm [NB];

  // w_view is the copy that accesses see; w_active drives current_settings.
  logic [7:0]        w_view   [NUM_BYTES];
  logic [7:0]        w_active [NUM_BYTES];

  logic [StructBytes-1:0][7:0] w_cur_bytes;
  settings_union_t             w_cur_u;

  // ---------------------------------------------------------------- control
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    commit_done  = 1'b0;
    case (r_state)
      IDLE: begin
        // A pending commit blocks new requests, so it wins over req_valid.
        req_ready = !r_commit_pend;
        if (r_commit_pend) begin
          w_state_next = COMMIT;
        end else if (req_valid) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      COMMIT: begin
        commit_done  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = |(req_addr & ALIGN_MASK);
  assign w_rsp_rdata  = (w_misaligned || req_write) ? '0 : w_lane_rdata;
  assign w_rsp_err    = w_misaligned || (|w_lane_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_commit_pend <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // A pulse arriving while the commit executes is kept for another pass.
      if (r_state == COMMIT) begin
        r_commit_pend <= commit;
      end else if (commit) begin
        r_commit_pend <= 1'b1;
      end
      if (w_accept) begin
        r_rsp_rdata <= w_rsp_rdata;
        r_rsp_err   <= w_rsp_err;
      end
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // ------------------------------------------------------------ byte lanes
  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    // Aligned addresses have zero low bits, so the lane offset never carries.
    assign w_lane_addr[gi] = req_addr + ADDR_W'(gi);
    assign w_lane_idx[gi]  = w_lane_addr[gi][IDX_W-1:0];

    settings_perm_decode #(
      .ADDR_W    (ADDR_W),
      .NUM_BYTES (NUM_BYTES),
      .RO_LAST   (RO_LAST)
    ) u_perm (
      .i_addr (w_lane_addr[gi]),
      .o_perm (w_lane_perm[gi])
    );

    assign w_lane_rdata[gi*8 +: 8] = (w_lane_perm[gi] == PermLocked) ? 8'h00
                                                                     : w_view[w_lane_idx[gi]];
    assign w_lane_we[gi]  = w_accept && req_write && !w_misaligned && req_wstrb[gi]
                            && (w_lane_perm[gi] == PermReadWrite);
    assign w_lane_bad[gi] = req_write ? (req_wstrb[gi] && (w_lane_perm[gi] != PermReadWrite))
                                      : (w_lane_perm[gi] == PermLocked);
  end

  // ---------------------------------------------------------- byte storage
  for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    logic       w_we;
    logic [7:0] w_wd;
    logic [7:0] r_act;

    always_comb begin
      w_we = 1'b0;
      w_wd = 8'h00;
      for (int l = 0; l < NB; l++) begin
        if (w_lane_we[l] && (w_lane_idx[l] == IDX_W'(gi))) begin
          w_we = 1'b1;
          w_wd = req_wdata[l*8 +: 8];
        end
      end
    end

`ifdef SETTINGS_SHADOW_EN
    logic [7:0] r_shd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shd <= default_byte(gi);
        r_act <= default_byte(gi);
      end else begin
        if (w_we) begin
          r_shd <= w_wd;
        end
        if (r_state == COMMIT) begin
          r_act <= r_shd;
        end
      end
    end

    assign w_view[gi] = r_shd;
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act <= default_byte(gi);
      end else if (w_we) begin
        r_act <= w_wd;
      end
    end

    assign w_view[gi] = r_act;
`endif

    assign w_active[gi] = r_act;
  end

`ifdef SETTINGS_SHADOW_EN
  logic r_shadow_dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_dirty <= 1'b0;
    end else if (r_state == COMMIT) begin
      r_shadow_dirty <= 1'b0;
    end else if (|w_lane_we) begin
      r_shadow_dirty <= 1'b1;
    end
  end

  assign shadow_dirty = r_shadow_dirty;
`else
  assign shadow_dirty = 1'b0;
`endif

  // ------------------------------------------------------- active image out
  for (gi = 0; gi < StructBytes; gi++) begin : g_cur
    if (gi < NUM_BYTES) begin : g_mapped
      assign w_cur_bytes[gi] = w_active[gi];
    end else begin : g_pad
      assign w_cur_bytes[gi] = 8'h00;
    end
  end

  assign w_cur_u.bytes    = w_cur_bytes;
  assign current_settings = w_cur_u.fields;

endmodule

// File: tb/tb_settings_shadow_bank.sv
// Testbench for settings_shadow_bank (DATA_W=32, NUM_BYTES=16, RO_LAST=3).
// A byte-level model of the image is updated by the stimulus tasks; a per-cycle
// process compares the active image, shadow_dirty, commit_done and rsp_valid
// against it, and the access tasks compare each response.
module tb_settings_shadow_bank;

`ifdef SETTINGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [127:0] DEF = 128'h00000000_00000100_00000001_0102A55A;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        commit;
  logic        commit_done;
  logic        shadow_dirty;
  memory_map::fpga_settings_t current_settings;
  logic [127:0] cur_bits;

  assign cur_bits = current_settings;

  settings_shadow_bank #(
    .DATA_W    (32),
    .ADDR_W    (8),
    .NUM_BYTES (16),
    .RO_LAST   (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_wstrb        (req_wstrb),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .commit           (commit),
    .commit_done      (commit_done),
    .shadow_dirty     (shadow_dirty),
    .current_settings (current_settings)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_active [16];
  logic [7:0] m_shadow [16];
  bit         m_dirty  = 1'b0;
  bit         exp_done = 1'b0;
  bit         exp_rsp  = 1'b0;
  bit         chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_cur();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  task automatic model_reset();
    logic [127:0] d;
    d = DEF;
    for (int i = 0; i < 16; i++) begin
      m_active[i] = d[i*8 +: 8];
      m_shadow[i] = d[i*8 +: 8];
    end
    m_dirty  = 1'b0;
    exp_done = 1'b0;
    exp_rsp  = 1'b0;
  endtask

  // 0 = locked, 1 = read-only, 2 = read-write
  function automatic int perm(input int a);
    if (a >= 16) return 0;
    if (a <= 3)  return 1;
    return 2;
  endfunction

  // Reads see the shadow copy; without a shadow both copies are kept equal.
  task automatic model_access(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rd, output logic err);
    logic [7:0] a8;
    rd  = 32'h0;
    err = 1'b0;
    if (addr % 4 != 0) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      a8 = addr + 8'(i);
      if (wr) begin
        if (strb[i]) begin
          if (perm(int'(a8)) == 2) begin
            m_shadow[a8[3:0]] = data[i*8 +: 8];
            if (SHADOW) m_dirty = 1'b1;
            else        m_active[a8[3:0]] = data[i*8 +: 8];
          end else begin
            err = 1'b1;
          end
        end
      end else begin
        if (perm(int'(a8)) == 0) err = 1'b1;
        else                     rd[i*8 +: 8] = m_shadow[a8[3:0]];
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle/current_settings", cur_bits, model_cur());
      check("cycle/shadow_dirty", 128'(shadow_dirty), 128'(m_dirty));
      check("cycle/commit_done", 128'(commit_done), 128'(exp_done));
      check("cycle/rsp_valid", 128'(rsp_valid), 128'(exp_rsp));
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic access(input string nm, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input int hold,
                        input bit with_commit, output logic [31:0] got_rd, output logic got_err);
    logic [31:0] e_rd;
    logic        e_err;
    int          waited;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    commit    = with_commit;
    waited    = 0;
    @(negedge clk);
    while (!req_ready && waited < 16) begin
      waited++;
      @(negedge clk);
    end
    check({nm, "/accept_wait"}, 128'(waited), 128'(0));
    if (!req_ready) begin
      req_valid = 1'b0;
      commit    = 1'b0;
      got_rd    = 32'hxxxx_xxxx;
      got_err   = 1'bx;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    commit    = 1'b0;
    model_access(wr, addr, data, strb, e_rd, e_err);
    exp_rsp = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check({nm, "/rsp_valid"}, 128'(rsp_valid), 128'(1));
      check({nm, "/req_ready_busy"}, 128'(req_ready), 128'(0));
      if (!wr) check({nm, "/rdata"}, 128'(rsp_rdata), 128'(e_rd));
      check({nm, "/err"}, 128'(rsp_err), 128'(e_err));
      if (h == hold) begin
        got_rd    = rsp_rdata;
        got_err   = rsp_err;
        rsp_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_rsp   = 1'b0;
  endtask

  // Pending commit: next edge enters COMMIT, the one after applies it.
  task automatic commit_tail();
    @(posedge clk);
    #1;
    exp_done = 1'b1;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
    m_dirty = 1'b0;
  endtask

  task automatic do_commit(input string nm);
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    @(negedge clk);
    check({nm, "/req_ready_pend"}, 128'(req_ready), 128'(0));
    commit_tail();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_bad=%0d", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0; commit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst/req_ready", 128'(req_ready), 128'(1));
    check("rst/rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst/rsp_rdata", 128'(rsp_rdata), 128'(0));
    check("rst/rsp_err", 128'(rsp_err), 128'(0));
    check("rst/commit_done", 128'(commit_done), 128'(0));
    check("rst/shadow_dirty", 128'(shadow_dirty), 128'(0));
    check("rst/current_settings", cur_bits, DEF);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full write to RW word, read back.
    access("wr04", 1'b1, 8'h04, 32'hAABBCCDD, 4'hF, 0, 1'b0, rd, er);
    check("wr04/err_lit", 128'(er), 128'(0));
    access("rd04", 1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd04/rdata_lit", 128'(rd), 128'(32'hAABBCCDD));
    check("rd04/err_lit", 128'(er), 128'(0));
    check("rd04/dirty_lit", 128'(shadow_dirty), 128'(SHADOW));
    check("rd04/ctrl_lit", 128'(cur_bits[63:32]), 128'(SHADOW ? 32'h00000001 : 32'hAABBCCDD));

    // Commit while idle.
    do_commit("commit1");
    check("commit1/ctrl_lit", 128'(cur_bits[63:32]), 128'(32'hAABBCCDD));
    check("commit1/dirty_lit", 128'(shadow_dirty), 128'(0));

    // Read-only word.
    access("wr00", 1'b1, 8'h00, 32'h11223344, 4'hF, 0, 1'b0, rd, er);
    check("wr00/err_lit", 128'(er), 128'(1));
    access("rd00", 1'b0, 8'h00, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd00/rdata_lit", 128'(rd), 128'(32'h0102A55A));
    check("rd00/err_lit", 128'(er), 128'(0));
    check("rd00/ro_bytes_lit", 128'(cur_bits[31:0]), 128'(32'h0102A55A));

    // Locked read.
    access("rd10", 1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd10/rdata_lit", 128'(rd), 128'(0));
    check("rd10/err_lit", 128'(er), 128'(1));

    // Misaligned write leaves storage alone.
    access("wr06", 1'b1, 8'h06, 32'h99999999, 4'hF, 0, 1'b0, rd, er);
    check("wr06/err_lit", 128'(er), 128'(1));
    access("rd04_after06", 1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd04_after06/rdata_lit", 128'(rd), 128'(32'hAABBCCDD));

    // Partial strobes, then a read held for 3 cycles.
    access("wr08_s5", 1'b1, 8'h08, 32'h12345678, 4'h5, 0, 1'b0, rd, er);
    check("wr08_s5/err_lit", 128'(er), 128'(0));
    access("rd08_hold", 1'b0, 8'h08, 32'h0, 4'h0, 3, 1'b0, rd, er);
    check("rd08_hold/rdata_lit", 128'(rd), 128'(32'h00340178));

    // Locked write, and a write with no strobes to a read-only word.
    access("wr10", 1'b1, 8'h10, 32'h0000BEEF, 4'h3, 0, 1'b0, rd, er);
    check("wr10/err_lit", 128'(er), 128'(1));
    access("wr00_s0", 1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 0, 1'b0, rd, er);
    check("wr00_s0/err_lit", 128'(er), 128'(0));

    // Commit pulse together with an accepted request: request first.
    access("wr0C_cm", 1'b1, 8'h0C, 32'hCAFEF00D, 4'hF, 0, 1'b1, rd, er);
    check("wr0C_cm/err_lit", 128'(er), 128'(0));
    @(negedge clk);
    check("wr0C_cm/req_ready_pend", 128'(req_ready), 128'(0));
    commit_tail();
    check("wr0C_cm/scratch_lit", 128'(cur_bits[127:96]), 128'(32'hCAFEF00D));

    // Reset while COMMIT is executing.
    access("wr04b", 1'b1, 8'h04, 32'h55667788, 4'hF, 0, 1'b0, rd, er);
    access("rd04b", 1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd04b/rdata_lit", 128'(rd), 128'(32'h55667788));
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rstc/rsp_valid", 128'(rsp_valid), 128'(0));
    check("rstc/rsp_rdata", 128'(rsp_rdata), 128'(0));
    check("rstc/rsp_err", 128'(rsp_err), 128'(0));
    check("rstc/commit_done", 128'(commit_done), 128'(0));
    check("rstc/shadow_dirty", 128'(shadow_dirty), 128'(0));
    check("rstc/req_ready", 128'(req_ready), 128'(1));
    check("rstc/current_settings", cur_bits, DEF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    access("rd04c", 1'b0, 8'h04, 32'h0, 4'h0, 0, 1'b0, rd, er);
    check("rd04c/rdata_lit", 128'(rd), 128'(32'h00000001));
    check("rd04c/err_lit", 128'(er), 128'(0));

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/settings_shadow_bank.md
SETTINGS_SHADOW_BANK -- requirements
Module: settings_shadow_bank

Interface
REQ-001 Parameter DATA_W, default 32, meaning access word width in bits (8, 16 or 32).
REQ-002 Parameter ADDR_W, default 8, meaning byte-address width.
REQ-003 Parameter NUM_BYTES, default memory_map::StructBytes, meaning settings image size in bytes.
REQ-004 Parameter RO_LAST, default memory_map::AddrReadOnly, meaning highest read-only byte address.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  byte address, aligned to DATA_W/8.
- req_wdata  in  DATA_W  write data, little-endian.
- req_wstrb  in  DATA_W/8  byte write enables.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  access fault flag.
- commit  in  1  single-cycle commit request pulse.
- commit_done  out  1  one-cycle pulse when the active image is updated.
- shadow_dirty  out  1  shadow differs from active by at least one accepted write.
- current_settings  out  memory_map::fpga_settings_t  active image.

Function
REQ-006 Per-byte permission: addr >= NUM_BYTES is locked; addr <= RO_LAST is read-only; all other addresses are read-write.
REQ-007 FSM states SHALL be IDLE, RESP and COMMIT.
REQ-008 req_ready SHALL equal (state==IDLE && !commit_pend).
REQ-009 Accepted request in IDLE SHALL go to RESP; rsp_valid=1 in RESP with rsp_rdata/rsp_err stable; rsp_valid && rsp_ready SHALL return to IDLE (minimum latency 1 cycle, no back-to-back acceptance).
REQ-010 A misaligned req_addr SHALL produce rsp_err=1, rsp_rdata=0 and no storage change.
REQ-011 A write SHALL update only RW bytes with strobe set.
REQ-012 Any strobed byte that is RO or locked SHALL be left unchanged and set rsp_err=1.
REQ-013 A read SHALL return stored bytes, with locked bytes returning 8'h00; rsp_err=1 if any byte in the word is locked.
REQ-014 A commit pulse SHALL set commit_pend in any state; repeated pulses SHALL merge.
REQ-015 IDLE with commit_pend SHALL go to COMMIT; commit SHALL take priority over a same-cycle req_valid.
REQ-016 In COMMIT: active <= shadow, commit_pend <= 0, shadow_dirty <= 0, commit_done=1 for exactly that cycle; next state IDLE.
REQ-017 A commit pulse coinciding with request acceptance SHALL let that request complete first, then commit.
REQ-018 shadow_dirty SHALL be set by any write that changes at least one byte's enable path (a strobed RW byte).

Reset
REQ-019 rst_n low SHALL asynchronously load active and shadow with memory_map::DefaultSettings and set: state=IDLE, commit_pend=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, commit_done=0, shadow_dirty=0.
REQ-020 Reset mid-response or mid-commit SHALL drop the transaction with no partial update.

Configuration
REQ-021 Macro SETTINGS_SHADOW_EN defined: writes target shadow, reads return shadow, and current_settings updates only on commit.
REQ-022 SETTINGS_SHADOW_EN undefined: no shadow storage; writes target active directly; commit still passes through COMMIT (commit_done pulse); shadow_dirty is tied to 0.

Structure
REQ-023 The package memory_map SHALL hold fpga_settings_t, settings_union_t, DefaultSettings, StructBytes, AddrReadOnly and permission_t (PermLocked, PermReadOnly, PermReadWrite).
REQ-024 Sub-module settings_perm_decode SHALL be used: byte address in, permission_t out, instantiated DATA_W/8 times.

Verification (DATA_W=32, NUM_BYTES=16, RO_LAST=3)
REQ-025 Write addr 0x04, wdata 0xAABBCCDD, wstrb 0xF, then read 0x04 -> rdata 0xAABBCCDD, err=0, shadow_dirty=1, current_settings unchanged.
REQ-026 Commit pulse, then idle -> commit_done pulse 2 cycles later; current_settings bytes 4..7 = DD,CC,BB,AA; shadow_dirty=0.
REQ-027 Write addr 0x00, wstrb 0xF -> err=1 and bytes 0..3 still equal DefaultSettings.
REQ-028 Read 0x10 -> rdata 0, err=1.
REQ-029 Write addr 0x06 -> err=1 (misaligned), storage unchanged.
REQ-030 Commit pulse and req_valid in the same cycle with state IDLE -> request accepted first, then COMMIT.
REQ-031 Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready=0.
REQ-032 Assert rst_n=0 during COMMIT -> all outputs at reset values and current_settings=DefaultSettings.
